// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: geometry plus Gray/binary pointer conversion.
package fifo_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // MSB-down XOR prefix.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] gray);
    logic [ADDR_WIDTH:0] bin;
    bin[ADDR_WIDTH] = gray[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_write_ctrl_flags.sv
// Async FIFO write-side controller: binary/Gray write pointers, registered
// full/almost-full flags, write-domain fill level and sticky overflow.
module fifo_write_ctrl_flags
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic                  ovf_clr,
  output logic                  wr_fire,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

  logic [ADDR_WIDTH:0] wr_bin_ptr;
  logic [ADDR_WIDTH:0] wr_bin_next;
  logic [ADDR_WIDTH:0] wr_gray_next;
  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] level_next;
  logic                af_next;
  logic                ovf_next;

  // Conversions are written width-generic so the module stays correct when
  // ADDR_WIDTH is overridden away from the package default.
  always_comb begin
    wr_fire      = wr_en && !full;
    wr_bin_next  = wr_bin_ptr + {{ADDR_WIDTH{1'b0}}, wr_fire};
    wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    rd_bin             = '0;
    rd_bin[ADDR_WIDTH] = rd_ptr_sync[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      rd_bin[i] = rd_bin[i+1] ^ rd_ptr_sync[i];
    end
    level_next = wr_bin_next - rd_bin;
    af_next    = (af_thresh != '0) && (level_next >= af_thresh);
    // A new overflow event outranks a simultaneous clear.
    ovf_next   = (wr_en && full) ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
  end

  assign wr_addr = wr_bin_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_ptr  <= '0;
      wr_gray_ptr <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin_ptr  <= wr_bin_next;
      wr_gray_ptr <= wr_gray_next;
      full        <= (level_next == DEPTH_W);
      almost_full <= af_next;
      wr_level    <= level_next;
      overflow    <= ovf_next;
    end
  end

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level_next <= DEPTH_W);
  a_full_level: assert property (@(posedge clk) disable iff (!rst_n)
    full |-> (wr_level == DEPTH_W));

endmodule

// File: tb/tb_fifo_write_ctrl_flags.sv
// Bench for fifo_write_ctrl_flags: directed walk-through plus random traffic
// compared every cycle against a counter-level model of the FIFO.
module tb_fifo_write_ctrl_flags;

  localparam int AW  = 3;
  localparam int DEP = 8;
  localparam int MOD = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW:0]   rd_ptr_sync;
  logic [AW:0]   af_thresh;
  logic          ovf_clr;
  logic          wr_fire;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_gray_ptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  // model state: words written and words read, counted modulo 2*DEPTH
  int m_wr, rd_cnt, m_lvl;
  bit m_full, m_af, m_ovf;

  fifo_write_ctrl_flags #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_ptr_sync(rd_ptr_sync),
    .af_thresh(af_thresh), .ovf_clr(ovf_clr), .wr_fire(wr_fire),
    .wr_addr(wr_addr), .wr_gray_ptr(wr_gray_ptr), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_rd(input int c);
    rd_cnt      = c % MOD;
    rd_ptr_sync = (AW+1)'(gray(rd_cnt));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      bit fire;
      fire = wr_en && !m_full;
      if (wr_en && m_full) m_ovf = 1;
      else if (ovf_clr)    m_ovf = 0;
      m_wr   = (m_wr + int'(fire)) % MOD;
      m_lvl  = (m_wr - rd_cnt + MOD) % MOD;
      m_full = (m_lvl == DEP);
      m_af   = (af_thresh != 0) && (m_lvl >= int'(af_thresh));
    end
  end

  always @(negedge clk) begin
    chk("wr_fire",     int'(wr_fire),     int'(wr_en && !m_full));
    chk("wr_addr",     int'(wr_addr),     m_wr % DEP);
    chk("wr_gray_ptr", int'(wr_gray_ptr), gray(m_wr));
    chk("full",        int'(full),        int'(m_full));
    chk("almost_full", int'(almost_full), int'(m_af));
    chk("wr_level",    int'(wr_level),    m_lvl);
    chk("overflow",    int'(overflow),    int'(m_ovf));
  end

  initial begin
    int exp_g [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    rst_n = 0; wr_en = 0; af_thresh = 0; ovf_clr = 0; set_rd(0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    // reset state
    @(posedge clk); #1;
    chk("rst_gray", int'(wr_gray_ptr), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(wr_level), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_af", int'(almost_full), 0);

    // fill to full, then one refused write
    #1 wr_en = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("fill_gray", int'(wr_gray_ptr), exp_g[k]);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(wr_level), 8);
    chk("refused_fire", int'(wr_fire), 0);
    chk("refused_addr", int'(wr_addr), 0);
    @(posedge clk); #1;
    chk("ovf_set", int'(overflow), 1);
    chk("held_gray", int'(wr_gray_ptr), 12);

    // one word read frees a slot; one write refills
    #1 wr_en = 0; set_rd(1);
    @(posedge clk); #1;
    chk("rd_full", int'(full), 0);
    chk("rd_level", int'(wr_level), 7);
    #1 wr_en = 1;
    @(posedge clk); #1;
    chk("refill_full", int'(full), 1);
    chk("refill_level", int'(wr_level), 8);

    // wrap: read pointer at bin 8, write until the write pointer wraps to 0
    #1 wr_en = 0; set_rd(8);
    @(posedge clk); #2 wr_en = 1;
    repeat (7) @(posedge clk);
    #1;
    chk("wrap_full", int'(full), 1);
    chk("wrap_level", int'(wr_level), 8);
    chk("wrap_gray", int'(wr_gray_ptr), 0);
    chk("wrap_addr", int'(wr_addr), 0);

    // almost-full threshold
    #1 wr_en = 0; rst_n = 0; set_rd(0); af_thresh = 6;
    @(posedge clk); #2 rst_n = 1; wr_en = 1;
    repeat (5) @(posedge clk);
    #1 chk("af_below", int'(almost_full), 0);
    @(posedge clk); #1;
    chk("af_rise", int'(almost_full), 1);
    chk("af_notfull", int'(full), 0);
    #1 wr_en = 0; af_thresh = 0;
    @(posedge clk); #1;
    chk("af_disabled", int'(almost_full), 0);

    // overflow set beats simultaneous clear
    #1 wr_en = 1;
    repeat (3) @(posedge clk);
    #1 chk("ovf_again", int'(overflow), 1);
    #1 ovf_clr = 1;
    @(posedge clk); #1;
    chk("ovf_set_wins", int'(overflow), 1);
    #1 wr_en = 0;
    @(posedge clk); #1;
    chk("ovf_cleared", int'(overflow), 0);

    // async reset mid-burst
    #1 ovf_clr = 0; wr_en = 1; set_rd(2);
    repeat (2) @(posedge clk);
    #2 rst_n = 0; set_rd(0);
    #1;
    chk("arst_gray", int'(wr_gray_ptr), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_level", int'(wr_level), 0);
    chk("arst_addr", int'(wr_addr), 0);
    chk("arst_af", int'(almost_full), 0);
    #1 wr_en = 0;
    @(posedge clk); #2 rst_n = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      wr_en   = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      if ((m_wr - rd_cnt + MOD) % MOD > 0 && $urandom_range(0, 2) == 0)
        set_rd(rd_cnt + 1);
      if ($urandom_range(0, 63) == 0)
        af_thresh = (AW+1)'($urandom_range(0, 10));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0; set_rd(0);
        @(posedge clk); #2 rst_n = 1;
      end
    end

    @(posedge clk); #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
